// File: rtl/sm2201_camac_cycle_sequencer_if.sv
// ISA I/O side and CAMAC branch side of the SM2201 cycle sequencer.
//   isa_*  : ISA slave port (strobes active-low, aen=1 means DMA cycle)
//   cb_*   : CAMAC branch port (address, data, direction, strobe, Q)
//   timeout_err : sticky CAMAC no-response flag
// slave  : the sequencer itself
// master : the environment (ISA host plus CAMAC responder)
interface sm2201_camac_cycle_sequencer_if;
    logic        isa_ior;
    logic        isa_iow;
    logic        isa_aen;
    logic [9:0]  isa_addr;
    logic [7:0]  isa_data_in;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe;
    logic        isa_chrdy;
    logic [11:0] cb_addr;
    logic [15:0] cb_data_out;
    logic [15:0] cb_data_in;
    logic        cb_b_b1;
    logic        cb_strobe;
    logic        cb_q;
    logic        timeout_err;

    modport slave (
        input  isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in, cb_data_in, cb_q,
        output isa_data_out, isa_data_oe, isa_chrdy, cb_addr, cb_data_out,
               cb_b_b1, cb_strobe, timeout_err
    );

    modport master (
        output isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in, cb_data_in, cb_q,
        input  isa_data_out, isa_data_oe, isa_chrdy, cb_addr, cb_data_out,
               cb_b_b1, cb_strobe, timeout_err
    );
endinterface

// File: rtl/sm2201_camac_cycle_sequencer.sv
// SM2201 ISA-to-CAMAC cycle sequencer.
// Five-byte I/O window at BASE_ADDR:
//   +0 data low byte (runs a CAMAC cycle), +1 data high-byte holding register,
//   +2 cb_addr[7:0], +3 cb_addr[11:8], +4 status {7'b0, timeout_err}.
// Ports:
//   isa_clk   : single system clock, all state on its rising edge
//   isa_reset : synchronous active-high reset
//   bus       : ISA + CAMAC signals (slave modport)
// An offset-0 access holds isa_chrdy low while the CAMAC cycle runs
// (SETUP -> STROBE -> WAIT_Q -> DONE) and releases it in DONE.
module sm2201_camac_cycle_sequencer #(
    parameter logic [9:0] BASE_ADDR      = 10'h106,
    parameter int         STROBE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                              isa_clk,
    input  logic                              isa_reset,
    sm2201_camac_cycle_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_Q, DONE} state_t;

    state_t      state, state_nxt;
    logic        ior_q, iow_q;
    logic        hit;
    logic [2:0]  off;
    logic        rd_start, wr_start, start;
    logic        is_wr;        // current CAMAC cycle is a write
    logic        q_seen;       // cb_q already observed in this cycle
    logic [3:0]  strobe_cnt;
    logic [7:0]  tmo_cnt;
    logic        strobe_last, tmo_last;
    logic [7:0]  hold;
    logic [7:0]  rd_data;
    logic [11:0] cb_addr_q;
    logic [15:0] cb_data_out_q;
    logic        tmo_err_q;
    logic [7:0]  reg_mux;

    assign hit = !bus.isa_aen && (bus.isa_addr >= BASE_ADDR) &&
                 ({1'b0, bus.isa_addr} <= ({1'b0, BASE_ADDR} + 11'd4));
    assign off = 3'(bus.isa_addr - BASE_ADDR);

    // A start needs a high-to-low transition seen on consecutive edges;
    // both strobes low together is treated as bus noise, not a cycle.
    assign rd_start = ior_q && !bus.isa_ior && bus.isa_iow;
    assign wr_start = iow_q && !bus.isa_iow && bus.isa_ior;
    assign start    = (state == IDLE) && hit && (rd_start || wr_start);

    assign strobe_last = (strobe_cnt == 4'(STROBE_CYCLES - 1));
    assign tmo_last    = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge isa_clk) begin
        if (isa_reset) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && off == 3'd0) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (strobe_last) state_nxt = WAIT_Q;
            // Timeout can only expire here because TIMEOUT_CYCLES > STROBE_CYCLES.
            WAIT_Q:  if (q_seen || bus.cb_q || tmo_last) state_nxt = DONE;
            DONE:    if (bus.isa_ior && bus.isa_iow) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            ior_q         <= 1'b1;
            iow_q         <= 1'b1;
            is_wr         <= 1'b0;
            q_seen        <= 1'b0;
            strobe_cnt    <= '0;
            tmo_cnt       <= '0;
            hold          <= '0;
            rd_data       <= '0;
            cb_addr_q     <= '0;
            cb_data_out_q <= '0;
            tmo_err_q     <= 1'b0;
        end else begin
            ior_q <= bus.isa_ior;
            iow_q <= bus.isa_iow;

            if (start && wr_start) begin
                case (off)
                    3'd0:    cb_data_out_q <= {hold, bus.isa_data_in};
                    3'd1:    hold <= bus.isa_data_in;
                    3'd2:    cb_addr_q[7:0] <= bus.isa_data_in;
                    3'd3:    cb_addr_q[11:8] <= bus.isa_data_in[3:0];
                    3'd4:    if (bus.isa_data_in[0]) tmo_err_q <= 1'b0;
                    default: ;
                endcase
            end
            if (start && off == 3'd0) begin
                is_wr  <= wr_start;
                q_seen <= 1'b0;
            end

            if (state == SETUP) begin
                strobe_cnt <= '0;
                tmo_cnt    <= '0;
            end
            if (state == STROBE) strobe_cnt <= strobe_cnt + 4'd1;
            if (state == STROBE || state == WAIT_Q) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                // Only the first Q response carries data for this cycle.
                if (bus.cb_q && !q_seen) begin
                    q_seen <= 1'b1;
                    if (!is_wr) begin
                        rd_data <= bus.cb_data_in[7:0];
                        hold    <= bus.cb_data_in[15:8];
                    end
                end
            end
            if (state == WAIT_Q && !q_seen && !bus.cb_q && tmo_last) begin
                tmo_err_q <= 1'b1;
                rd_data   <= 8'hFF;
                hold      <= 8'hFF;
            end
        end
    end

    always_comb begin
        reg_mux = rd_data;
        case (off)
            3'd1:    reg_mux = hold;
            3'd2:    reg_mux = cb_addr_q[7:0];
            3'd3:    reg_mux = {4'h0, cb_addr_q[11:8]};
            3'd4:    reg_mux = {7'h00, tmo_err_q};
            default: reg_mux = rd_data;
        endcase
    end

    assign bus.isa_data_out = hit ? reg_mux : rd_data;
    assign bus.isa_data_oe  = hit && !bus.isa_ior;
    assign bus.isa_chrdy    = (state == IDLE) || (state == DONE);
    assign bus.cb_strobe    = (state == STROBE);
    assign bus.cb_b_b1      = is_wr && (state == SETUP || state == STROBE || state == WAIT_Q);
    assign bus.cb_addr      = cb_addr_q;
    assign bus.cb_data_out  = cb_data_out_q;
    assign bus.timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_sm2201_camac_cycle_sequencer.sv
module tb_sm2201_camac_cycle_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm2201_camac_cycle_sequencer_if bus ();

    sm2201_camac_cycle_sequencer #(
        .BASE_ADDR(10'h106), .STROBE_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .isa_clk  (clk),
        .isa_reset(rst),
        .bus      (bus)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ISA access. q_at: active-cycle index (1 = first strobe cycle)
    // at which cb_q pulses for one cycle; -1 = never.
    task automatic access(input logic wr, input logic [9:0] a, input logic [7:0] wd,
                          input int q_at, input logic [15:0] din,
                          output logic [7:0] rd, output int stb, output int low,
                          output logic bb1, output logic oe, output logic to);
        int   act;
        logic started;
        act = 0; started = 1'b0;
        stb = 0; low = 0; bb1 = 1'b0; oe = 1'b0; to = 1'b1;
        bus.isa_addr    = a;
        bus.isa_data_in = wd;
        bus.cb_data_in  = din;
        if (wr) bus.isa_iow = 1'b0;
        else    bus.isa_ior = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bus.isa_chrdy) low++;
            if (bus.cb_strobe) begin stb++; started = 1'b1; end
            if (bus.cb_b_b1) bb1 = 1'b1;
            if (bus.isa_data_oe) oe = 1'b1;
            if (started && !bus.isa_chrdy) act++;
            bus.cb_q = (act == q_at) && !bus.isa_chrdy;
            if (bus.isa_chrdy && (low > 0 || i >= 2)) begin to = 1'b0; break; end
        end
        rd = bus.isa_data_out;
        bus.cb_q    = 1'b0;
        bus.isa_ior = 1'b1;
        bus.isa_iow = 1'b1;
        tick();
        tick();
    endtask

    logic [7:0] rd;
    int         stb, low;
    logic       bb1, oe, to;
    int         acc_stb, acc_low;
    logic       acc_bb1, acc_oe;
    logic       bound_ok;

    initial begin
        bus.isa_ior = 1'b1; bus.isa_iow = 1'b1; bus.isa_aen = 1'b0;
        bus.isa_addr = '0; bus.isa_data_in = '0; bus.cb_data_in = '0; bus.cb_q = 1'b0;
        tick(); tick(); tick();
        chk("rst_chrdy",   16'(bus.isa_chrdy), 16'h1);
        chk("rst_strobe",  16'(bus.cb_strobe), 16'h0);
        chk("rst_bb1",     16'(bus.cb_b_b1), 16'h0);
        chk("rst_cbaddr",  16'(bus.cb_addr), 16'h0);
        chk("rst_cbdout",  bus.cb_data_out, 16'h0);
        chk("rst_dout",    16'(bus.isa_data_out), 16'h0);
        chk("rst_tmo",     16'(bus.timeout_err), 16'h0);
        rst = 1'b0;
        tick();

        // CAMAC read with Q on the second strobe cycle
        access(1'b0, 10'h106, 8'h00, 2, 16'hA55A, rd, stb, low, bb1, oe, to);
        chk("rd0_bound",  16'(to), 16'h0);
        chk("rd0_data",   16'(rd), 16'h5A);
        chk("rd0_stb",    16'(stb), 16'd4);
        chk("rd0_waits",  16'(low > 0), 16'h1);
        chk("rd0_bb1",    16'(bb1), 16'h0);
        chk("rd0_oe",     16'(oe), 16'h1);
        access(1'b0, 10'h107, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("rd1_data",   16'(rd), 16'hA5);
        chk("rd1_nowait", 16'(low), 16'd0);
        chk("rd1_nostb",  16'(stb), 16'd0);

        // CAMAC write: high byte via holding register, then low byte
        access(1'b1, 10'h107, 8'h12, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("wr1_nowait", 16'(low), 16'd0);
        chk("wr1_nostb",  16'(stb), 16'd0);
        access(1'b1, 10'h106, 8'h34, 1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("wr0_bound",  16'(to), 16'h0);
        chk("wr0_stb",    16'(stb), 16'd4);
        chk("wr0_bb1",    16'(bb1), 16'h1);
        chk("wr0_dout",   bus.cb_data_out, 16'h1234);
        chk("wr0_oe",     16'(oe), 16'h0);
        chk("wr0_bb1_after", 16'(bus.cb_b_b1), 16'h0);

        // Address registers
        access(1'b1, 10'h108, 8'hAB, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        access(1'b1, 10'h109, 8'hFC, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("cbaddr",     16'(bus.cb_addr), 16'h0CAB);
        access(1'b0, 10'h109, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("rd3_data",   16'(rd), 16'h0C);
        access(1'b0, 10'h108, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("rd2_data",   16'(rd), 16'hAB);

        // Q first seen after the strobe ends (in WAIT_Q)
        access(1'b0, 10'h106, 8'h00, 6, 16'hBE77, rd, stb, low, bb1, oe, to);
        chk("rdw_bound",  16'(to), 16'h0);
        chk("rdw_data",   16'(rd), 16'h77);
        chk("rdw_stb",    16'(stb), 16'd4);
        chk("rdw_tmo",    16'(bus.timeout_err), 16'h0);

        // Timeout: Q never arrives
        access(1'b0, 10'h106, 8'h00, -1, 16'h1111, rd, stb, low, bb1, oe, to);
        chk("to_bound",   16'(to), 16'h0);
        chk("to_waits",   16'(low), 16'd65);
        chk("to_data",    16'(rd), 16'hFF);
        chk("to_flag",    16'(bus.timeout_err), 16'h1);
        access(1'b0, 10'h107, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("to_hold",    16'(rd), 16'hFF);
        access(1'b0, 10'h10A, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("to_status",  16'(rd), 16'h01);
        access(1'b1, 10'h10A, 8'hFE, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("clr_bit0only", 16'(bus.timeout_err), 16'h1);
        access(1'b1, 10'h10A, 8'h01, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("clr_flag",   16'(bus.timeout_err), 16'h0);
        access(1'b0, 10'h10A, 8'h00, -1, 16'h0000, rd, stb, low, bb1, oe, to);
        chk("clr_status", 16'(rd), 16'h00);

        // Non-hit and DMA cycles leave the bus alone
        acc_stb = 0; acc_low = 0; acc_bb1 = 1'b0; acc_oe = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.isa_aen = (k >= 3);
            access(1'b0, (k >= 3) ? 10'h106 : 10'h120, 8'h00, -1, 16'h0000,
                   rd, stb, low, bb1, oe, to);
            acc_stb += stb; acc_low += low; acc_bb1 |= bb1; acc_oe |= oe;
        end
        bus.isa_aen = 1'b0;
        chk("nohit_oe",   16'(acc_oe), 16'h0);
        chk("nohit_stb",  16'(acc_stb), 16'd0);
        chk("nohit_bb1",  16'(acc_bb1), 16'h0);
        chk("nohit_wait", 16'(acc_low), 16'd0);

        // Reset in the middle of a strobe
        bus.isa_addr = 10'h106;
        bus.isa_ior  = 1'b0;
        bound_ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cb_strobe) begin bound_ok = 1'b1; break; end
        end
        chk("mid_strobe_seen", 16'(bound_ok), 16'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_chrdy",  16'(bus.isa_chrdy), 16'h1);
        chk("mid_rst_strobe", 16'(bus.cb_strobe), 16'h0);
        chk("mid_rst_cbaddr", 16'(bus.cb_addr), 16'h0);
        rst = 1'b0;
        bus.isa_ior = 1'b1;
        tick(); tick();
        chk("mid_idle_strobe", 16'(bus.cb_strobe), 16'h0);
        access(1'b0, 10'h106, 8'h00, 1, 16'h3C3C, rd, stb, low, bb1, oe, to);
        chk("post_bound", 16'(to), 16'h0);
        chk("post_data",  16'(rd), 16'h3C);
        chk("post_stb",   16'(stb), 16'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sm2201_camac_cycle_sequencer.md
SM2201_CAMAC_CYCLE_SEQUENCER -- requirements
Module: sm2201_camac_cycle_sequencer

Interface
REQ-001 Parameter BASE_ADDR, 10'h106, ISA I/O base; window is BASE_ADDR..BASE_ADDR+4.
REQ-002 Parameter STROBE_CYCLES, 4, cb_strobe width in isa_clk cycles (range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, 64, max cycles from strobe start to cb_q before abort (range STROBE_CYCLES+1..255).
REQ-004 Single clock isa_clk; reset isa_reset is synchronous and active-high; all state updates on rising isa_clk.
REQ-005 isa_clk  in  1  system clock.
REQ-006 isa_reset  in  1  synchronous active-high reset.
REQ-007 isa_ior / isa_iow  in  1 each  ISA read/write strobes, active-low.
REQ-008 isa_aen  in  1  DMA address enable; 1 = ignore the cycle.
REQ-009 isa_addr  in  10  ISA I/O address.
REQ-010 isa_data_in  in  8  ISA write data.
REQ-011 isa_data_out  out  8  ISA read data; isa_data_oe  out  1  ISA data driver enable.
REQ-012 isa_chrdy  out  1  channel ready; 0 = insert wait states.
REQ-013 cb_addr  out  12  CAMAC address register.
REQ-014 cb_data_out  out  16  CAMAC write data; cb_data_in  in  16  CAMAC read data.
REQ-015 cb_b_b1  out  1  CAMAC data direction; 1 = block drives cb_data.
REQ-016 cb_strobe  out  1  CAMAC cycle strobe; cb_q  in  1  CAMAC response.
REQ-017 timeout_err  out  1  sticky timeout flag.

Function
REQ-018 Hit = isa_aen==0 and isa_addr in window; offset = isa_addr - BASE_ADDR.
REQ-019 Start event = registered ior (or iow) samples high then low on consecutive edges with hit, in IDLE; ior and iow both low = no event.
REQ-020 Offset map: 0 = data low byte (CAMAC cycle); 1 = data high-byte holding register; 2 = cb_addr[7:0]; 3 = cb_addr[11:8] in bits 3:0, bits 7:4 read 0; 4 = status {7'b0, timeout_err}.
REQ-021 Writes to offsets 1..3 update their register on the start-event edge, no CAMAC cycle, chrdy stays 1.
REQ-022 Write offset 4 with data bit0=1 clears timeout_err; other bits ignored.
REQ-023 Reads of offsets 1..4 return their register without a CAMAC cycle or wait states.
REQ-024 Write offset 0 starts CAMAC write with cb_data_out={high holding, isa_data_in}; read offset 0 starts CAMAC read.
REQ-025 FSM states IDLE, SETUP, STROBE, WAIT_Q, DONE; CAMAC cycles only enter SETUP.
REQ-026 IDLE->SETUP on offset-0 start event; isa_chrdy=0 from that edge.
REQ-027 SETUP lasts 1 cycle; cb_b_b1=1 in SETUP, STROBE, WAIT_Q for writes only.
REQ-028 STROBE: cb_strobe=1 for exactly STROBE_CYCLES cycles, then WAIT_Q; cb_q sampled from first STROBE cycle.
REQ-029 cb_q=1 at any cycle in STROBE/WAIT_Q: latch cb_data_in (read: low byte to isa_data_out, high byte to holding), go DONE after strobe completes.
REQ-030 Timeout counter starts at 0 on STROBE entry; reaching TIMEOUT_CYCLES without cb_q sets timeout_err, read data = 8'hFF, holding = 8'hFF, go DONE.
REQ-031 DONE: isa_chrdy=1, cb_strobe=0, cb_b_b1=0; stay until ior and iow both high, then IDLE.
REQ-032 isa_data_oe = ior low and hit, combinational; 0 otherwise (bus passivity on all non-hit cycles).
REQ-033 cb_b_b1=0 at all times outside write SETUP/STROBE/WAIT_Q.
REQ-034 ISA strobe released mid-cycle: CAMAC cycle still completes; DONE exits immediately after.

Reset
REQ-035 On isa_reset=1: state IDLE, isa_chrdy=1, cb_strobe=0, cb_b_b1=0, cb_addr=0, cb_data_out=0, holding=0, isa_data_out=0, timeout_err=0, counters 0; applies mid-cycle with no completion.

Verification
REQ-036 Read isa_addr=10'h106, cb_q=1 at 2nd strobe cycle, cb_data_in=16'hA55A -> chrdy low until DONE, isa_data_out=8'h5A, then read 10'h107 returns 8'hA5, no cycle.
REQ-037 Write 10'h107=8'h12, 10'h106=8'h34 -> one CAMAC cycle, cb_b_b1=1, cb_data_out=16'h1234, cb_strobe high 4 cycles.
REQ-038 Read 10'h106, cb_q held 0 -> chrdy released after 64 cycles, data 8'hFF, status read 10'h10A = 8'h01; write 10'h10A=8'h01 clears it.
REQ-039 Repeated reads of 10'h120 and isa_aen=1 reads of 10'h106 -> isa_data_oe=0, cb_strobe=0, cb_b_b1=0, chrdy=1 throughout.
REQ-040 isa_reset asserted during STROBE -> next edge chrdy=1, cb_strobe=0, state IDLE; subsequent read completes normally.
